// File: rtl/axi_pkg.sv
// Purpose: shared AXI4 constants and the read-master state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Reused by the read/write masters and slaves so burst type, beat size and
// response encodings stay consistent across the fabric.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } axi_state_t;

endpackage

// File: rtl/axi_master_rd.sv
// Purpose: single-burst AXI4 read master; issues one AR, streams R beats to the user.
// Latency: rd_start -> arvalid 1 cycle; R beats pass through combinationally; rd_done 1 cycle after last beat.
// Backpressure: user rd_data_ready drives m_axi_rready directly; new commands accepted only in IDLE.
//
// Ports:
//   clk, rst              - shared clock, asynchronous active-high reset
//   rd_start/addr/len     - command strobe, start address, AXI length (beats = len+1)
//   rd_req_ready          - command accepted this cycle when high (IDLE only)
//   rd_data_*             - beat stream to the user, valid/ready
//   rd_done, rd_err       - end-of-burst pulse and its error qualifier
//   m_axi_ar*, m_axi_r*   - AXI4 read-address and read-data channels
module axi_master_rd
    import axi_pkg::*;
#(
    parameter logic [3:0] ARID    = 4'd0,
    parameter logic [3:0] ARCACHE = 4'b0010
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        rd_start,
    input  logic [29:0] rd_addr_in,
    input  logic [7:0]  rd_len_in,
    output logic        rd_req_ready,

    output logic [63:0] rd_data_out,
    output logic        rd_data_valid,
    input  logic        rd_data_ready,
    output logic        rd_done,
    output logic        rd_err,

    output logic [3:0]  m_axi_arid,
    output logic [29:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arlock,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic [3:0]  m_axi_arqos,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    axi_state_t state;
    logic [7:0] cnt_beat;
    logic       err_flag;

    logic       in_r;
    logic       r_hs;
    logic       last_pos;
    logic       beat_err;

    // Constant AR attributes: fixed 8-byte INCR bursts, no locking/QoS.
    assign m_axi_arid    = ARID;
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = ARCACHE;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;

    // Combinational so it reads 1 while held in reset (state is IDLE there).
    assign rd_req_ready = (state == IDLE);

    // Zero-latency data path. Gating with the state means a reset mid-burst
    // drops rready at once and no stray beats are consumed.
    assign in_r          = (state == R);
    assign rd_data_out   = m_axi_rdata;
    assign rd_data_valid = m_axi_rvalid & in_r;
    assign m_axi_rready  = rd_data_ready & in_r;

    assign r_hs     = m_axi_rvalid & m_axi_rready;
    // Beat position comes from our own count; rlast is only cross-checked.
    assign last_pos = (cnt_beat == m_axi_arlen);
    assign beat_err = (m_axi_rresp != AXI_RESP_OKAY) | (m_axi_rlast != last_pos);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            cnt_beat      <= '0;
            err_flag      <= 1'b0;
            rd_done       <= 1'b0;
            rd_err        <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            rd_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        m_axi_araddr  <= rd_addr_in;
                        m_axi_arlen   <= rd_len_in;
                        cnt_beat      <= '0;
                        err_flag      <= 1'b0;
                        m_axi_arvalid <= 1'b1;
                        state         <= AR;
                    end
                end
                AR: begin
                    // arvalid/araddr/arlen hold until the slave takes them.
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state         <= R;
                    end
                end
                R: begin
                    if (r_hs) begin
                        cnt_beat <= cnt_beat + 8'd1;
                        err_flag <= err_flag | beat_err;
                        if (last_pos) begin
                            // Fold in the final beat's own check for rd_err.
                            rd_done <= 1'b1;
                            rd_err  <= err_flag | beat_err;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    m_axi_arvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
